csa_tree_pipe: RTL and testbench
================================

# csa_tree_pipe

Pipelined, parametrised carry-save adder tree with valid/ready handshake and an optional multi-beat accumulate mode. It reduces NUM_INPUTS operands of IN_WIDTH bits with levels of 3:2 compressors, inserts a register bank after every LEVELS_PER_STAGE levels, and resolves the sum with a registered carry-propagate adder and accumulator. It is the streaming reduction stage for dot-product PEs, where whole dot products are summed over several beats.

## Interface
- NUM_INPUTS, 16, operands per beat (>=1)
- IN_WIDTH, 31, operand width
- OUT_WIDTH, 35, result/accumulator width (>= IN_WIDTH); all arithmetic modulo 2^OUT_WIDTH
- LEVELS_PER_STAGE, 2, 3:2 levels between pipeline registers (>=1)
- SIGNED, 0, 1: operands sign-extended; 0: zero-extended
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat offered
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  NUM_INPUTS*IN_WIDTH  operand k at bits [k*IN_WIDTH +: IN_WIDTH]
- in_acc  in  1  beat belongs to an accumulation group
- in_last  in  1  closes an accumulation group (ignored when in_acc=0)
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid && out_ready
- out_sum  out  OUT_WIDTH  resolved result
- out_last  out  1  result closes an accumulation group

## Operation
- LEVELS: start n=NUM_INPUTS; while n>2: n = n - floor(n/3), LEVELS++. Defaults give 6 levels (16,11,8,6,4,3,2).
- Each level groups rows in threes from index 0: sum = a^b^c, carry = maj(a,b,c)<<1, truncated to OUT_WIDTH. Leftover 1–2 rows pass through. Row order after a level is sum0, carry0, sum1, carry1, ..., then leftovers.
- Operands are extended to OUT_WIDTH at entry per SIGNED.
- Pipeline: P = ceil(LEVELS/LEVELS_PER_STAGE) tree register banks, each with a valid bit and in_acc/in_last sideband, followed by one output stage.
- Output stage: a CPA adds the two remaining rows. If only one row remains, the second row is 0.
- Single global advance: adv = !out_valid || out_ready. in_ready = adv. All banks load on adv. Bubbles carry valid=0.
- Output stage on adv, with an incoming valid beat of sum S:
  - in_acc=0: out_sum=S, out_last=0, out_valid=1. acc unchanged.
  - in_acc=1, last=0: acc += S. out_valid=0.
  - in_acc=1, last=1: out_sum = acc+S, out_last=1, out_valid=1, acc=0.
- Output stage on adv with no valid incoming beat: out_valid=0.
- Non-acc beats may be interleaved within an open group. They do not disturb acc.
- Reset (any time, asynchronous):
  - all valid bits = 0, acc = 0, out_valid = 0, out_sum = 0, out_last = 0.
  - in_ready = 1 while rst is asserted and after it is released.
  - In-flight beats are discarded.

## Timing
- Latency: accepted beat to out_valid is L = P+1 cycles when out_ready stays 1. Defaults: P=3, L=4. NUM_INPUTS<=2 gives P=0, L=1.
- Throughput: 1 beat/cycle with out_ready=1.
- out_ready=0 while out_valid=1:
  - whole pipe freezes and in_ready=0 in the same cycle.
  - out_sum/out_last stay stable.
  - no beat is lost or duplicated.
- in_ready depends combinationally on out_ready and out_valid only, never on in_valid.
- out_valid=0 keeps the pipe advancing even with out_ready=0. Bubbles collapse only at the output stage.
- Overflow wraps modulo 2^OUT_WIDTH. No saturation, no flag.

## Structure
- Package csa_tree_pkg:
  - function csa_levels(n) returning LEVELS.
  - function csa_rows_after(n, k) returning the row count after k levels.
  - function csa_stages(levels, lps) returning P.
- Sub-module csa_3to2_level: purely combinational, parameters ROWS_IN and WIDTH. Instantiated once per level via generate; register banks are placed between groups of levels.
- The output stage (CPA, acc, output regs) stays in the top.

## Test plan
- Reset: rst=1 mid-stream with 3 beats in flight -> out_valid=0, in_ready=1, acc=0 immediately. Next accumulate group starts from 0.
- Unsigned max: all 16 operands 31'h7FFF_FFFF, in_acc=0 -> out_sum=35'h7_FFFF_FFF0 exactly 4 cycles after accept.
- Signed: SIGNED=1, operand k = k-8 (k=0..15) -> out_sum=35'h7_FFFF_FFF8 (-8).
- Backpressure: stream 6 random beats back-to-back, hold out_ready=0 for 5 cycles after first out_valid -> in_ready=0 during hold, out_sum stable, all 6 sums emerge in order and match the reference model.
- Accumulate: 3 beats, in_acc=1, operand0 = 1, 2, 3 (others 0), in_last on third -> exactly one out_valid, out_sum=6, out_last=1. A following non-acc beat with operand0=5 -> out_sum=5, out_last=0.
- Config sweep: NUM_INPUTS in {1, 2, 3, 7, 16} × LEVELS_PER_STAGE in {1, 3} -> latency equals P+1 and random sums match the model modulo 2^OUT_WIDTH.

Source files
------------

// File: rtl/csa_tree_pkg.sv
// Shared elaboration helpers for the pipelined carry-save adder tree:
// level counts, per-level row counts and pipeline bank counts.
package csa_tree_pkg;

  // Rows left after k levels of 3:2 compression, starting from n rows.
  function automatic int csa_rows_after(input int n, input int k);
    int r;
    r = n;
    for (int i = 0; i < k; i++) begin
      if (r > 2) r = r - r / 3;
    end
    return r;
  endfunction

  function automatic int csa_levels(input int n);
    int r;
    int l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = r - r / 3;
      l++;
    end
    return l;
  endfunction

  function automatic int csa_stages(input int levels, input int lps);
    return (levels + lps - 1) / lps;
  endfunction

endpackage

// File: rtl/csa_3to2_level.sv
// One combinational level of 3:2 compressors. Rows are grouped in threes from
// row 0; output order is sum0, carry0, sum1, carry1, ..., then leftover rows.
module csa_3to2_level
  import csa_tree_pkg::*;
#(
  parameter int ROWS_IN = 3,
  parameter int WIDTH = 8,
  localparam int ROWS_OUT = csa_rows_after(ROWS_IN, 1)
) (
  input  logic [ROWS_IN*WIDTH-1:0]  rows_i,
  output logic [ROWS_OUT*WIDTH-1:0] rows_o
);

  localparam int GROUPS = ROWS_IN / 3;
  localparam int LEFT = ROWS_IN - 3 * GROUPS;

  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    logic [WIDTH-1:0] a, b, c, maj;
    assign a = rows_i[(3*g)*WIDTH +: WIDTH];
    assign b = rows_i[(3*g+1)*WIDTH +: WIDTH];
    assign c = rows_i[(3*g+2)*WIDTH +: WIDTH];
    assign maj = (a & b) | (a & c) | (b & c);
    assign rows_o[(2*g)*WIDTH +: WIDTH] = a ^ b ^ c;
    // Carry row is shifted one place left; the bit out of the top is dropped.
    assign rows_o[(2*g+1)*WIDTH +: WIDTH] = maj << 1;
  end

  for (genvar r = 0; r < LEFT; r++) begin : g_left
    assign rows_o[(2*GROUPS+r)*WIDTH +: WIDTH] = rows_i[(3*GROUPS+r)*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined carry-save reduction of NUM_INPUTS operands with a registered
// carry-propagate adder and multi-beat accumulator at the output.
module csa_tree_pipe
  import csa_tree_pkg::*;
#(
  parameter int NUM_INPUTS = 16,
  parameter int IN_WIDTH = 31,
  parameter int OUT_WIDTH = 35,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int SIGNED = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*IN_WIDTH-1:0]   in_data,
  input  logic                             in_acc,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_WIDTH-1:0]             out_sum,
  output logic                             out_last
);

  localparam int LEVELS = csa_levels(NUM_INPUTS);
  localparam int P = csa_stages(LEVELS, LEVELS_PER_STAGE);
  localparam int FINAL_ROWS = csa_rows_after(NUM_INPUTS, LEVELS);
  localparam int OW = OUT_WIDTH;

  // Handshake: a beat moves on any edge where valid && ready. One global
  // advance freezes every bank while a result waits unconsumed, so in_ready
  // depends only on out_valid/out_ready and never on in_valid.
  logic adv;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;

  logic [NUM_INPUTS*OW-1:0] ext_rows;
  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_ext
    if (SIGNED != 0) begin : g_s
      assign ext_rows[k*OW +: OW] = OW'($signed(in_data[k*IN_WIDTH +: IN_WIDTH]));
    end else begin : g_u
      assign ext_rows[k*OW +: OW] = OW'(in_data[k*IN_WIDTH +: IN_WIDTH]);
    end
  end

  // Level l reads either the previous level or, at a stage boundary, a bank.
  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int RI = csa_rows_after(NUM_INPUTS, l - 1);
    localparam int RO = csa_rows_after(NUM_INPUTS, l);
    localparam bit FROM_BANK = (l > 1) && (((l - 1) % LEVELS_PER_STAGE) == 0);
    localparam int SB = (l - 1) / LEVELS_PER_STAGE - 1;
    logic [RI*OW-1:0] src;
    logic [RO*OW-1:0] res;
    if (l == 1) begin : g_first
      assign src = ext_rows;
    end else if (FROM_BANK) begin : g_bank
      assign src = g_stg[SB].bank_q;
    end else begin : g_comb
      assign src = g_lvl[l-1].res;
    end
    csa_3to2_level #(.ROWS_IN(RI), .WIDTH(OW)) u_level (
      .rows_i(src),
      .rows_o(res)
    );
  end

  for (genvar s = 0; s < P; s++) begin : g_stg
    localparam int E = ((s + 1) * LEVELS_PER_STAGE < LEVELS) ? (s + 1) * LEVELS_PER_STAGE : LEVELS;
    localparam int RB = csa_rows_after(NUM_INPUTS, E);
    logic [RB*OW-1:0] bank_q;
    logic v_q, acc_q, last_q;
    logic v_d, acc_d, last_d;
    if (s == 0) begin : g_head
      assign v_d = in_valid;
      assign acc_d = in_acc;
      assign last_d = in_last;
    end else begin : g_body
      assign v_d = g_stg[s-1].v_q;
      assign acc_d = g_stg[s-1].acc_q;
      assign last_d = g_stg[s-1].last_q;
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        bank_q <= '0;
        v_q <= 1'b0;
        acc_q <= 1'b0;
        last_q <= 1'b0;
      end else if (adv) begin
        bank_q <= g_lvl[E].res;
        v_q <= v_d;
        acc_q <= acc_d;
        last_q <= last_d;
      end
    end
  end

  logic [FINAL_ROWS*OW-1:0] fin_rows;
  logic fin_v, fin_acc, fin_last;
  if (P > 0) begin : g_fin_bank
    assign fin_rows = g_stg[P-1].bank_q;
    assign fin_v = g_stg[P-1].v_q;
    assign fin_acc = g_stg[P-1].acc_q;
    assign fin_last = g_stg[P-1].last_q;
  end else begin : g_fin_direct
    assign fin_rows = ext_rows;
    assign fin_v = in_valid;
    assign fin_acc = in_acc;
    assign fin_last = in_last;
  end

  logic [OW-1:0] row_b, cpa_sum;
  if (FINAL_ROWS > 1) begin : g_two
    assign row_b = fin_rows[OW +: OW];
  end else begin : g_one
    assign row_b = '0;
  end
  assign cpa_sum = fin_rows[0 +: OW] + row_b;

  logic [OW-1:0] acc_q, acc_d, sum_q, sum_d;
  logic valid_q, valid_d, olast_q, olast_d;

  always_comb begin
    acc_d = acc_q;
    sum_d = sum_q;
    valid_d = valid_q;
    olast_d = olast_q;
    if (adv) begin
      valid_d = 1'b0;
      if (fin_v) begin
        if (!fin_acc) begin
          sum_d = cpa_sum;
          olast_d = 1'b0;
          valid_d = 1'b1;
        end else if (!fin_last) begin
          acc_d = acc_q + cpa_sum;
        end else begin
          sum_d = acc_q + cpa_sum;
          olast_d = 1'b1;
          valid_d = 1'b1;
          acc_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      sum_q <= '0;
      valid_q <= 1'b0;
      olast_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sum_q <= sum_d;
      valid_q <= valid_d;
      olast_q <= olast_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sum = sum_q;
  assign out_last = olast_q;

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Bench for csa_tree_pipe: default instance checked through an expected-result
// queue, plus a signed instance and a two-operand instance for latency/sign.
module tb_csa_tree_pipe;
  localparam int N = 16;
  localparam int IW = 31;
  localparam int OW = 35;
  localparam int DW = N * IW;

  logic clk, rst;
  logic in_valid, in_ready, in_acc, in_last, out_valid, out_ready, out_last;
  logic [DW-1:0] in_data;
  logic [OW-1:0] out_sum;

  logic s_in_valid, s_in_ready, s_out_valid, s_out_last;
  logic [DW-1:0] s_in_data;
  logic [OW-1:0] s_out_sum;

  logic t_in_valid, t_in_ready, t_out_valid, t_out_last;
  logic [2*IW-1:0] t_in_data;
  logic [OW-1:0] t_out_sum;

  logic [35:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic hold_chk = 1'b0;
  logic [OW-1:0] held_sum;
  logic held_last;

  csa_tree_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_acc(in_acc), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_last(out_last)
  );

  csa_tree_pipe #(.NUM_INPUTS(16), .IN_WIDTH(31), .OUT_WIDTH(35), .LEVELS_PER_STAGE(3), .SIGNED(1)) u_sgn (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .in_acc(1'b0), .in_last(1'b0), .out_valid(s_out_valid), .out_ready(1'b1),
    .out_sum(s_out_sum), .out_last(s_out_last)
  );

  csa_tree_pipe #(.NUM_INPUTS(2), .IN_WIDTH(31), .OUT_WIDTH(35), .LEVELS_PER_STAGE(1), .SIGNED(0)) u_two (
    .clk(clk), .rst(rst), .in_valid(t_in_valid), .in_ready(t_in_ready), .in_data(t_in_data),
    .in_acc(1'b0), .in_last(1'b0), .out_valid(t_out_valid), .out_ready(1'b1),
    .out_sum(t_out_sum), .out_last(t_out_last)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] ref_sum(input logic [DW-1:0] d);
    logic [OW-1:0] s;
    s = '0;
    for (int k = 0; k < N; k++) s = s + OW'(d[k*IW +: IW]);
    return s;
  endfunction

  function automatic logic [DW-1:0] op0(input logic [IW-1:0] v);
    return DW'(v);
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < N; k++) d[k*IW +: IW] = IW'($urandom());
    return d;
  endfunction

  // Driver: called at a falling edge, returns at the falling edge after accept.
  task automatic send(input logic [DW-1:0] d, input logic a, input logic l, input logic [OW-1:0] e);
    int g = 0;
    in_valid = 1'b1;
    in_data = d;
    in_acc = a;
    in_last = l;
    #2;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      #2;
      g++;
    end
    n_cmp++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", g);
    end else if (!a || l) begin
      exp_q.push_back({a & l, e});
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_acc = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_latency(input int lat_exp);
    int c = 1;
    #2;
    while (!out_valid && c < 20) begin
      @(negedge clk);
      #2;
      c++;
    end
    check("latency", 64'(c), 64'(lat_exp));
  endtask

  task automatic sgn_beat(input logic [DW-1:0] d, input logic [OW-1:0] e);
    int c = 1;
    s_in_valid = 1'b1;
    s_in_data = d;
    @(negedge clk);
    s_in_valid = 1'b0;
    #2;
    while (!s_out_valid && c < 20) begin
      @(negedge clk);
      #2;
      c++;
    end
    check("sgn_latency", 64'(c), 64'd3);
    check("sgn_sum", 64'(s_out_sum), 64'(e));
    check("sgn_last", 64'(s_out_last), 64'd0);
  endtask

  task automatic two_beat(input logic [2*IW-1:0] d, input logic [OW-1:0] e);
    int c = 1;
    t_in_valid = 1'b1;
    t_in_data = d;
    @(negedge clk);
    t_in_valid = 1'b0;
    #2;
    while (!t_out_valid && c < 20) begin
      @(negedge clk);
      #2;
      c++;
    end
    check("two_latency", 64'(c), 64'd1);
    check("two_sum", 64'(t_out_sum), 64'(e));
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    #2;
    if (rst) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_sum", 64'(out_sum), 64'(held_sum));
        check("hold_last", 64'(out_last), 64'(held_last));
      end
      if (out_valid && !out_ready) begin
        check("in_ready_stall", 64'(in_ready), 64'd0);
        hold_chk = 1'b1;
        held_sum = out_sum;
        held_last = out_last;
      end else begin
        hold_chk = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got sum %0h last %0b, required no output", out_sum, out_last);
        end else begin
          logic [35:0] e;
          e = exp_q.pop_front();
          check("out_sum", 64'(out_sum), 64'(e[34:0]));
          check("out_last", 64'(out_last), 64'(e[35]));
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [DW-1:0] maxd, sd;
    int g;
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_acc = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; t_in_valid = 1'b0; t_in_data = '0;
    for (int k = 0; k < N; k++) maxd[k*IW +: IW] = 31'h7FFF_FFFF;

    idle(2);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_sum", 64'(out_sum), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    rst = 1'b0;
    idle(1);

    // Unsigned maximum, with latency measurement
    send(maxd, 1'b0, 1'b0, 35'h7_FFFF_FFF0);
    check_latency(4);
    idle(3);

    // Accumulate group then a plain beat
    send(op0(31'd1), 1'b1, 1'b0, '0);
    send(op0(31'd2), 1'b1, 1'b0, '0);
    send(op0(31'd3), 1'b1, 1'b1, 35'd6);
    send(op0(31'd5), 1'b0, 1'b0, 35'd5);
    idle(6);

    // Plain beat interleaved inside an open group
    send(op0(31'd10), 1'b1, 1'b0, '0);
    send(op0(31'd7), 1'b0, 1'b0, 35'd7);
    send(op0(31'd20), 1'b1, 1'b1, 35'd30);
    // Accumulator wraps modulo 2^35
    send(maxd, 1'b1, 1'b0, '0);
    send(maxd, 1'b1, 1'b0, '0);
    send(maxd, 1'b1, 1'b1, 35'h7_FFFF_FFD0);

    // Back-to-back random beats
    for (int i = 0; i < 8; i++) begin
      sd = rand_data();
      send(sd, 1'b0, 1'b0, ref_sum(sd));
    end
    idle(6);

    // Backpressure: stall 5 cycles after first result while 6 beats stream in
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [DW-1:0] rd;
          rd = rand_data();
          send(rd, 1'b0, 1'b0, ref_sum(rd));
        end
      end
      begin
        g = 0;
        while (!out_valid && g < 50) begin
          @(negedge clk);
          g++;
        end
        check("bp_first_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        idle(5);
        out_ready = 1'b1;
      end
    join
    idle(8);

    // Reset with a partial sum in acc and three beats in flight
    send(op0(31'd100), 1'b1, 1'b0, '0);
    idle(6);
    send(op0(31'd1), 1'b1, 1'b0, '0);
    send(op0(31'd9), 1'b0, 1'b0, 35'd9);
    send(op0(31'd1), 1'b1, 1'b0, '0);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_sum", 64'(out_sum), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    send(op0(31'd1), 1'b1, 1'b0, '0);
    send(op0(31'd2), 1'b1, 1'b0, '0);
    send(op0(31'd3), 1'b1, 1'b1, 35'd6);

    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    idle(4);

    // Signed instance: operands k-8 sum to -8; all most-negative sum to -2^34
    for (int k = 0; k < N; k++) sd[k*IW +: IW] = IW'(k - 8);
    sgn_beat(sd, 35'h7_FFFF_FFF8);
    for (int k = 0; k < N; k++) sd[k*IW +: IW] = 31'h4000_0000;
    sgn_beat(sd, 35'h4_0000_0000);

    // Two-operand instance: no tree banks, single-cycle latency
    two_beat({31'h7FFF_FFFF, 31'h7FFF_FFFF}, 35'h0_FFFF_FFFE);
    two_beat({31'd5, 31'd7}, 35'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
